ddr2_port_arbiter: RTL and testbench

- Single-clock scheduler that shares the one DDR2 controller port between the capture-side writer (drains the write FIFO) and the display-side reader (fills the read FIFO).
- Generates frame-wrapped word addresses for both sides.
- Enforces bounded write bursts and an urgency override when the read FIFO runs low.
- Sits in the ctrl_clk domain between the two dual-clock FIFOs and the DDR2 system.

---
 rtl/ddr2_arb_pkg.sv | 19 +
 rtl/ddr2_port_arbiter_if.sv | 39 +++
 rtl/ddr2_frame_addr_gen.sv | 38 +++
 rtl/ddr2_port_arbiter.sv | 131 +++++++++++++
 tb/tb_ddr2_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr2_arb_pkg.sv
// Shared types for the DDR2 port arbiter.
// Holds FSM state, grant side and word sizing.
package ddr2_arb_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    GAP   = 2'd3
  } state_e;

  typedef enum logic {
    GR_WRITE = 1'b0,
    GR_READ  = 1'b1
  } grant_e;

endpackage

// File: rtl/ddr2_port_arbiter_if.sv
// FIFO-side and DDR2-side signals of the port arbiter.
// master = arbiter, slave = FIFOs plus DDR2 controller.
interface ddr2_port_arbiter_if;

  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_pop;
  logic        rd_enable;
  logic        rd_space;
  logic [8:0]  rd_level;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_waitrequest;
  logic        wr_frame_done;
  logic        rd_frame_done;
  logic        frame_ready;

  modport master (
    input  wr_valid, wr_data, rd_enable, rd_space, rd_level,
    input  mem_rdata, mem_waitrequest,
    output wr_pop, rd_data, rd_data_valid, mem_addr, mem_write,
    output mem_wdata, mem_read, wr_frame_done, rd_frame_done,
    output frame_ready
  );

  modport slave (
    output wr_valid, wr_data, rd_enable, rd_space, rd_level,
    output mem_rdata, mem_waitrequest,
    input  wr_pop, rd_data, rd_data_valid, mem_addr, mem_write,
    input  mem_wdata, mem_read, wr_frame_done, rd_frame_done,
    input  frame_ready
  );

endinterface

// File: rtl/ddr2_frame_addr_gen.sv
// Frame-wrapped word index counter with byte-address output.
// done_o pulses when the last word of a frame is consumed.
module ddr2_frame_addr_gen
  import ddr2_arb_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 307200,
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  localparam int unsigned IW =
    (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  output logic [31:0] addr_o,
  output logic        done_o
);

  localparam logic [IW-1:0] LAST = IW'(FRAME_WORDS - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic          at_last;

  assign at_last = (idx_q == LAST);
  assign done_o  = adv_i & at_last;
  assign addr_o  = BASE_ADDR
                 + (32'(idx_q) << $clog2(WORD_BYTES));

  always_comb begin
    idx_d = idx_q;
    if (adv_i) idx_d = at_last ? '0 : idx_q + IW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) idx_q <= '0;
    else       idx_q <= idx_d;
  end

endmodule

// File: rtl/ddr2_port_arbiter.sv
// Shares one DDR2 port between the capture writer and
// display reader with bounded bursts and urgent reads.
module ddr2_port_arbiter
  import ddr2_arb_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BURST_MAX   = 16,
  parameter int unsigned RD_URGENT   = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd0
) (
  input  logic ctrl_clk,
  input  logic reset,
  ddr2_port_arbiter_if.master bus
);

  localparam int unsigned BW = $clog2(BURST_MAX + 1);

  state_e        state_q, state_d;
  grant_e        last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          rdy_q, rdy_d;

  logic        rd_elig, rd_urgent, wr_elig, more;
  logic        go_rd, go_wr;
  logic        in_wr, in_rd, wr_acc, rd_acc;
  logic        wr_done, rd_done;
  logic [31:0] wr_addr, rd_addr;

  assign rd_elig   = bus.rd_enable & bus.rd_space & rdy_q;
  assign rd_urgent = rd_elig & (32'(bus.rd_level) < RD_URGENT);
  assign wr_elig   = bus.wr_valid;
  assign more      = burst_q < BW'(BURST_MAX);

  // Alternate on contention; urgent read always wins.
  assign go_rd = rd_urgent
               | (rd_elig & ~(wr_elig & (last_q == GR_READ)));
  assign go_wr = wr_elig & ~go_rd;

  assign in_wr  = (state_q == WRITE);
  assign in_rd  = (state_q == READ);
  assign wr_acc = in_wr & ~bus.mem_waitrequest;
  assign rd_acc = in_rd & ~bus.mem_waitrequest;
  assign rdy_d  = rdy_q | wr_done;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        unique case (1'b1)
          go_rd: begin
            state_d = READ;
            last_d  = GR_READ;
            burst_d = '0;
          end
          go_wr: begin
            state_d = WRITE;
            last_d  = GR_WRITE;
            burst_d = '0;
          end
          default: ;
        endcase
      end
      WRITE, READ: begin
        if (wr_acc | rd_acc) begin
          burst_d = burst_q + BW'(1);
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
        if (last_q == GR_WRITE) begin
          if (more & wr_elig & ~rd_urgent) state_d = WRITE;
        end else if (more & rd_elig) begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= GR_READ;
      burst_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      rdy_q   <= rdy_d;
    end
  end

  ddr2_frame_addr_gen #(
    .FRAME_WORDS (FRAME_WORDS),
    .BASE_ADDR   (BASE_ADDR)
  ) u_wr_gen (
    .clk_i  (ctrl_clk),
    .rst_i  (reset),
    .adv_i  (wr_acc),
    .addr_o (wr_addr),
    .done_o (wr_done)
  );

  ddr2_frame_addr_gen #(
    .FRAME_WORDS (FRAME_WORDS),
    .BASE_ADDR   (BASE_ADDR)
  ) u_rd_gen (
    .clk_i  (ctrl_clk),
    .rst_i  (reset),
    .adv_i  (rd_acc),
    .addr_o (rd_addr),
    .done_o (rd_done)
  );

  assign bus.mem_write     = in_wr;
  assign bus.mem_read      = in_rd;
  assign bus.mem_addr      = in_wr ? wr_addr
                           : in_rd ? rd_addr : '0;
  assign bus.mem_wdata     = in_wr ? bus.wr_data : '0;
  assign bus.wr_pop        = wr_acc;
  assign bus.rd_data_valid = rd_acc;
  assign bus.rd_data       = rd_acc ? bus.mem_rdata : '0;
  assign bus.wr_frame_done = wr_done;
  assign bus.rd_frame_done = rd_done;
  assign bus.frame_ready   = rdy_q;

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Randomized and directed bench for ddr2_port_arbiter.
// Transaction-level scoreboard checks every accepted word.
module tb_ddr2_port_arbiter;

  localparam int FW = 24;
  localparam int BM = 16;
  localparam int RU = 64;
  localparam logic [31:0] BASE = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr2_port_arbiter_if bus();

  ddr2_port_arbiter #(
    .FRAME_WORDS (FW),
    .BURST_MAX   (BM),
    .RD_URGENT   (RU),
    .BASE_ADDR   (BASE)
  ) dut (
    .ctrl_clk (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  bit rnd = 0, d_wv = 0, d_en = 0, d_sp = 0, d_wait = 0;
  logic [8:0] d_lvl = '0;
  bit pop_seen = 0;

  // Show-ahead write FIFO: head changes only after a pop.
  initial begin
    bus.wr_valid = 0; bus.wr_data = $urandom;
    bus.rd_enable = 0; bus.rd_space = 0; bus.rd_level = '0;
    bus.mem_rdata = '0; bus.mem_waitrequest = 0;
    forever begin
      @(posedge clk); #1;
      bus.mem_rdata = $urandom;
      if (pop_seen) bus.wr_data = $urandom;
      if (rnd) begin
        if (pop_seen || !bus.wr_valid)
          bus.wr_valid = ($urandom_range(3) != 0);
        bus.rd_enable = ($urandom_range(7) != 0);
        bus.rd_space  = ($urandom_range(3) != 0);
        bus.rd_level  = 9'($urandom_range(511));
        bus.mem_waitrequest = ($urandom_range(3) == 0);
      end else begin
        bus.wr_valid  = d_wv;
        bus.rd_enable = d_en;
        bus.rd_space  = d_sp;
        bus.rd_level  = d_lvl;
        bus.mem_waitrequest = d_wait;
      end
    end
  end

  int exp_w = 0, exp_r = 0;
  bit exp_rdy = 0;
  bit prev_stall = 0, prev_acc = 0;
  logic [33:0] prev_ctl;
  logic [31:0] prev_wd;
  int idle_run = 0, run = 0, n_wpop = 0;
  bit last_side = 0, seen = 0;
  bit acc_q[$];
  bit bs_q[$];
  int bl_q[$];

  always @(negedge clk) begin : mon
    bit wa, ra, side;
    if (rst) begin
      exp_w = 0; exp_r = 0; exp_rdy = 0;
      prev_stall = 0; prev_acc = 0;
      idle_run = 0; run = 0; seen = 0; pop_seen = 0;
      acc_q.delete(); bs_q.delete(); bl_q.delete();
    end else begin
      wa = bus.mem_write & ~bus.mem_waitrequest;
      ra = bus.mem_read & ~bus.mem_waitrequest;
      chk("excl", bus.mem_write & bus.mem_read, 0);
      chk("frdy", bus.frame_ready, exp_rdy);
      chk("wpop", bus.wr_pop, wa);
      chk("rdv", bus.rd_data_valid, ra);
      chk("wfd", bus.wr_frame_done, wa && exp_w == FW-1);
      chk("rfd", bus.rd_frame_done, ra && exp_r == FW-1);
      if (prev_acc)
        chk("gap", bus.mem_write | bus.mem_read, 0);
      if (prev_stall) begin
        chk("hold_ctl", {bus.mem_write, bus.mem_read,
                         bus.mem_addr}, prev_ctl);
        chk("hold_wd", bus.mem_wdata, prev_wd);
      end
      if (wa) begin
        chk("waddr", bus.mem_addr, BASE + 32'(exp_w) * 4);
        chk("wdata", bus.mem_wdata, bus.wr_data);
        if (exp_w == FW-1) begin
          exp_w = 0; exp_rdy = 1;
        end else exp_w++;
      end
      if (ra) begin
        chk("rd_gated", exp_rdy, 1);
        chk("raddr", bus.mem_addr, BASE + 32'(exp_r) * 4);
        chk("rdata", bus.rd_data, bus.mem_rdata);
        exp_r = (exp_r == FW-1) ? 0 : exp_r + 1;
      end
      if (wa || ra) begin
        side = ra;
        if (seen && idle_run == 1) begin
          chk("cont_side", side, last_side);
          run++;
          chk("burst_max", run <= BM, 1);
        end else begin
          if (seen) begin
            bs_q.push_back(last_side);
            bl_q.push_back(run);
          end
          run = 1;
        end
        seen = 1; last_side = side; idle_run = 0;
        acc_q.push_back(side);
      end else if (!(bus.mem_write | bus.mem_read)) begin
        idle_run++;
      end
      prev_acc   = wa | ra;
      prev_stall = (bus.mem_write | bus.mem_read)
                 & bus.mem_waitrequest;
      prev_ctl   = {bus.mem_write, bus.mem_read, bus.mem_addr};
      prev_wd    = bus.mem_wdata;
      pop_seen   = bus.wr_pop;
      if (bus.wr_pop) n_wpop++;
    end
  end

  task automatic tick();
    @(negedge clk); #2;
  endtask

  initial begin
    int k, nw, nb0, na0, base;
    bit found;

    repeat (3) tick();
    chk("rst_mw", bus.mem_write, 0);
    chk("rst_mr", bus.mem_read, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wd", bus.mem_wdata, 0);
    chk("rst_misc", {bus.wr_pop, bus.rd_data_valid,
                     bus.wr_frame_done, bus.rd_frame_done,
                     bus.frame_ready}, 0);
    chk("rst_rd", bus.rd_data, 0);

    // Write-only start: urgent read is blocked until a frame exists.
    d_wv = 1; d_en = 1; d_sp = 1; d_lvl = 0; d_wait = 0;
    rst = 0;
    tick();
    chk("lat_idle", bus.mem_write, 0);
    tick();
    chk("lat_req", bus.mem_write, 1);
    k = 0;
    while (acc_q.size() < FW + 1 && k < 300) begin
      tick(); k++;
    end
    chk("p2_done", acc_q.size() >= FW + 1, 1);
    nw = 0;
    while (nw < acc_q.size() && acc_q[nw] == 0) nw++;
    chk("wr_before_rd", nw, FW);
    chk("burst1_len", bl_q.size() > 0 ? bl_q[0] : 0, BM);

    // Non-urgent contention: alternate full bursts.
    d_lvl = 200;
    nb0 = bl_q.size();
    k = 0;
    while (bl_q.size() < nb0 + 5 && k < 800) begin
      tick(); k++;
    end
    chk("alt_done", bl_q.size() >= nb0 + 5, 1);
    if (bl_q.size() >= nb0 + 5)
      for (int i = nb0 + 1; i < nb0 + 5; i++) begin
        chk("alt_len", bl_q[i], BM);
        chk("alt_side", bs_q[i], !bs_q[i-1]);
      end

    // Urgent read after the 5th write of a burst.
    found = 0; k = 0;
    while (!found && k < 300) begin
      tick(); k++;
      found = bus.wr_pop && last_side == 0 && run == 5;
    end
    chk("w5_seen", found, 1);
    d_lvl = 10;
    na0 = acc_q.size();
    k = 0;
    while (acc_q.size() <= na0 && k < 50) begin
      tick(); k++;
    end
    chk("urg_next", acc_q.size() > na0 ? acc_q[na0] : 0, 1);
    d_lvl = 200;
    found = 0; k = 0;
    while (!found && k < 200) begin
      tick(); k++;
      found = bus.wr_pop;
    end
    chk("wr_resume", found, 1);

    // Seven-cycle stall on a write request.
    d_en = 0;
    repeat (40) tick();
    d_wait = 1;
    found = 0; k = 0;
    while (!found && k < 50) begin
      tick(); k++;
      found = bus.mem_write && bus.mem_waitrequest;
    end
    chk("stall_seen", found, 1);
    base = n_wpop;
    repeat (6) tick();
    chk("stall_nopop", n_wpop - base, 0);
    chk("stall_req", bus.mem_write, 1);
    d_wait = 0;
    tick();
    chk("stall_pop", n_wpop - base, 1);

    // Reset with a read outstanding.
    d_wv = 0; d_en = 1; d_lvl = 200;
    repeat (40) tick();
    d_wait = 1;
    found = 0; k = 0;
    while (!found && k < 80) begin
      tick(); k++;
      found = bus.mem_read && bus.mem_waitrequest;
    end
    chk("rd_out_seen", found, 1);
    rst = 1;
    tick();
    chk("rr_mr", bus.mem_read, 0);
    chk("rr_addr", bus.mem_addr, 0);
    chk("rr_misc", {bus.rd_data_valid, bus.frame_ready,
                    bus.mem_write}, 0);
    rst = 0; d_wv = 1; d_wait = 0; d_lvl = 0;
    k = 0;
    while (acc_q.size() < 3 && k < 50) begin
      tick(); k++;
    end
    chk("rr_first_wr",
        acc_q.size() > 0 ? acc_q[0] : 1'b1, 0);

    rnd = 1;
    repeat (3000) tick();
    rnd = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
